// File: rtl/soc_ifc_mc_arb.sv
// Multi-client / multi-target request arbiter: address decode + per-target round-robin with hold lock.
// Optional per-target collision counters are enabled with `define SOC_IFC_ARB_COLL_CNT_EN.
package soc_ifc_mc_arb_pkg;
  localparam int SOC_IFC_ADDR_W = 32;
  localparam int SOC_IFC_DATA_W = 32;
  localparam int SOC_IFC_USER_W = 8;

  typedef struct packed {
    logic [SOC_IFC_ADDR_W-1:0] addr;
    logic [SOC_IFC_DATA_W-1:0] wdata;
    logic                      write;
    logic [SOC_IFC_USER_W-1:0] user;
  } soc_ifc_req_t;
endpackage

// One arbiter per target: round-robin among hitting clients, locked to the owner while the target holds.
module soc_ifc_mc_arb_tgt #(
  parameter int NUM_CLIENTS = 3,
  parameter int IW          = $clog2(NUM_CLIENTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] hit,
  input  logic                   tgt_hold,
  input  logic                   coll_cnt_clr,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic [15:0]            coll_cnt
);
  logic [IW-1:0] rr_ptr, lock_owner, gnt_idx;
  logic          lock_vld, gnt_any, done, multi;
  int            k;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = 0;
    if (lock_vld) begin
      gnt_idx = lock_owner;
      gnt_any = hit[lock_owner];
    end else begin
      // Descending scan so the last match is the nearest client at/after rr_ptr.
      for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
        k = (int'(rr_ptr) + i) % NUM_CLIENTS;
        if (hit[k]) begin
          gnt_idx = IW'(k);
          gnt_any = 1'b1;
        end
      end
    end
    if (rst) gnt_any = 1'b0;
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign done  = gnt_any && !tgt_hold;
  assign multi = (hit & (hit - NUM_CLIENTS'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      lock_vld   <= 1'b0;
      lock_owner <= '0;
    end else begin
      // No grant while locked means the owner dropped its request; release.
      if (gnt_any) begin
        lock_vld   <= tgt_hold;
        lock_owner <= gnt_idx;
      end else begin
        lock_vld   <= 1'b0;
      end
      if (done && multi)
        rr_ptr <= (gnt_idx == IW'(NUM_CLIENTS-1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  a_lock_owner_keeps_req: assert property (@(posedge clk) disable iff (rst) lock_vld |-> hit[lock_owner]);

`ifdef SOC_IFC_ARB_COLL_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || coll_cnt_clr)
      cnt_q <= '0;
    else if (done && multi && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end
  assign coll_cnt = cnt_q;
`else
  logic clr_unused;
  assign clr_unused = coll_cnt_clr;
  assign coll_cnt   = '0;
`endif
endmodule

module soc_ifc_mc_arb
  import soc_ifc_mc_arb_pkg::*;
#(
  parameter int                                 NUM_CLIENTS    = 3,
  parameter int                                 NUM_TGTS       = 4,
  parameter logic [NUM_TGTS-1:0][31:0]          TGT_START_ADDR = '0,
  parameter logic [NUM_TGTS-1:0][31:0]          TGT_END_ADDR   = '0,
  parameter logic [NUM_TGTS-1:0][NUM_CLIENTS-1:0] TGT_CLIENT_EN = '1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic         [NUM_CLIENTS-1:0]               cli_req_dv,
  input  soc_ifc_req_t [NUM_CLIENTS-1:0]               cli_req_data,
  output logic         [NUM_CLIENTS-1:0]               cli_req_hold,
  output logic         [NUM_CLIENTS-1:0][SOC_IFC_DATA_W-1:0] cli_rdata,
  output logic         [NUM_CLIENTS-1:0]               cli_error,
  output logic         [NUM_TGTS-1:0]                  tgt_req_dv,
  output soc_ifc_req_t [NUM_TGTS-1:0]                  tgt_req_data,
  input  logic         [NUM_TGTS-1:0]                  tgt_req_hold,
  input  logic         [NUM_TGTS-1:0][SOC_IFC_DATA_W-1:0] tgt_rdata,
  input  logic         [NUM_TGTS-1:0]                  tgt_error,
  output logic         [NUM_TGTS-1:0][15:0]            coll_cnt,
  input  logic                                         coll_cnt_clr
);
  logic [NUM_TGTS-1:0][NUM_CLIENTS-1:0] hit, gnt;
  logic [NUM_CLIENTS-1:0]               cli_hit;

  always_comb begin
    hit = '0;
    for (int t = 0; t < NUM_TGTS; t++)
      for (int c = 0; c < NUM_CLIENTS; c++)
        hit[t][c] = cli_req_dv[c] && TGT_CLIENT_EN[t][c] &&
                    (cli_req_data[c].addr >= TGT_START_ADDR[t]) &&
                    (cli_req_data[c].addr <= TGT_END_ADDR[t]);
  end

  for (genvar t = 0; t < NUM_TGTS; t++) begin : g_tgt
    soc_ifc_mc_arb_tgt #(.NUM_CLIENTS(NUM_CLIENTS)) u_arb (
      .clk          (clk),
      .rst          (rst),
      .hit          (hit[t]),
      .tgt_hold     (tgt_req_hold[t]),
      .coll_cnt_clr (coll_cnt_clr),
      .gnt          (gnt[t]),
      .coll_cnt     (coll_cnt[t])
    );
  end

  // Grants are one-hot per target and ranges never overlap, so AND-OR muxing is safe in both directions.
  always_comb begin
    tgt_req_dv   = '0;
    tgt_req_data = '0;
    cli_req_hold = '0;
    cli_rdata    = '0;
    cli_error    = '0;
    cli_hit      = '0;
    for (int t = 0; t < NUM_TGTS; t++) begin
      tgt_req_dv[t] = |gnt[t];
      for (int c = 0; c < NUM_CLIENTS; c++) begin
        cli_hit[c] = cli_hit[c] | hit[t][c];
        if (gnt[t][c]) begin
          tgt_req_data[t] = tgt_req_data[t] | cli_req_data[c];
          cli_rdata[c]    = cli_rdata[c] | tgt_rdata[t];
          cli_error[c]    = cli_error[c] | tgt_error[t];
        end
        if (hit[t][c] && (!gnt[t][c] || tgt_req_hold[t]))
          cli_req_hold[c] = 1'b1;
      end
    end
    if (rst)
      cli_req_hold = cli_req_dv;
    else
      cli_error = cli_error | (cli_req_dv & ~cli_hit);
  end
endmodule

// File: tb/tb_soc_ifc_mc_arb.sv
// Directed bench for soc_ifc_mc_arb: vector table for arbitration/decode/reset, plus mask and counter sequences.
module tb_soc_ifc_mc_arb;
  import soc_ifc_mc_arb_pkg::*;

  localparam int          NC  = 3;
  localparam int          NT  = 4;
  localparam logic [31:0] T0  = 32'h0000_0100;
  localparam logic [31:0] T1  = 32'h0000_1100;
  localparam logic [31:0] T2  = 32'h0000_2100;
  localparam logic [31:0] T3  = 32'h0000_3100;
  localparam logic [31:0] BAD = 32'h0000_8000;
  localparam logic [NT-1:0][31:0] START = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [NT-1:0][31:0] ENDA  = {32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF};
  localparam logic [NT-1:0][NC-1:0] EN_B = {3'b111, 3'b111, 3'b111, 3'b011};

  logic clk = 1'b0;
  logic rst, coll_cnt_clr;
  logic         [NC-1:0]       cli_req_dv;
  soc_ifc_req_t [NC-1:0]       cli_req_data;
  logic         [NC-1:0]       cli_req_hold, cli_error, b_cli_req_hold, b_cli_error;
  logic         [NC-1:0][31:0] cli_rdata, b_cli_rdata;
  logic         [NT-1:0]       tgt_req_dv, tgt_req_hold, tgt_error, b_tgt_req_dv;
  soc_ifc_req_t [NT-1:0]       tgt_req_data, b_tgt_req_data;
  logic         [NT-1:0][31:0] tgt_rdata;
  logic         [NT-1:0][15:0] coll_cnt, b_coll_cnt;

  logic [31:0] trd [NT];
  logic [31:0] av  [NC];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  soc_ifc_mc_arb #(.NUM_CLIENTS(NC), .NUM_TGTS(NT), .TGT_START_ADDR(START),
                   .TGT_END_ADDR(ENDA), .TGT_CLIENT_EN('1)) u_dut (
    .clk(clk), .rst(rst), .cli_req_dv(cli_req_dv), .cli_req_data(cli_req_data),
    .cli_req_hold(cli_req_hold), .cli_rdata(cli_rdata), .cli_error(cli_error),
    .tgt_req_dv(tgt_req_dv), .tgt_req_data(tgt_req_data), .tgt_req_hold(tgt_req_hold),
    .tgt_rdata(tgt_rdata), .tgt_error(tgt_error), .coll_cnt(coll_cnt), .coll_cnt_clr(coll_cnt_clr));

  // Second instance: client 2 not permitted on target 0.
  soc_ifc_mc_arb #(.NUM_CLIENTS(NC), .NUM_TGTS(NT), .TGT_START_ADDR(START),
                   .TGT_END_ADDR(ENDA), .TGT_CLIENT_EN(EN_B)) u_dut_b (
    .clk(clk), .rst(rst), .cli_req_dv(cli_req_dv), .cli_req_data(cli_req_data),
    .cli_req_hold(b_cli_req_hold), .cli_rdata(b_cli_rdata), .cli_error(b_cli_error),
    .tgt_req_dv(b_tgt_req_dv), .tgt_req_data(b_tgt_req_data), .tgt_req_hold(tgt_req_hold),
    .tgt_rdata(tgt_rdata), .tgt_error(tgt_error), .coll_cnt(b_coll_cnt), .coll_cnt_clr(coll_cnt_clr));

  typedef struct {
    logic        r;
    logic [2:0]  dv;
    logic [31:0] a0, a1, a2;
    logic [3:0]  th, tdv;
    logic [2:0]  hold, err, gnt;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic r, input logic [2:0] dv, input logic [31:0] a0, a1, a2,
                     input logic [3:0] th, tdv, input logic [2:0] hold, err, gnt);
    vq.push_back('{r, dv, a0, a1, a2, th, tdv, hold, err, gnt});
  endtask

  task automatic drive(input logic r, input logic [2:0] dv, input logic [31:0] a0, a1, a2,
                       input logic [3:0] th, input logic clr);
    rst = r; cli_req_dv = dv; tgt_req_hold = th; coll_cnt_clr = clr;
    av[0] = a0; av[1] = a1; av[2] = a2;
    for (int c = 0; c < NC; c++)
      cli_req_data[c] = '{addr: av[c], wdata: 32'hD000_0000 | c, write: c[0], user: 8'(c)};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int tgt_of(input logic [31:0] a);
    return int'(a[15:12]);
  endfunction

  initial begin
    soc_ifc_req_t exp_d;
    logic [31:0]  exp_rd;
    trd[0] = 32'hA5A5_0000; trd[1] = 32'h1111_1111; trd[2] = 32'h0000_5A5A; trd[3] = 32'h3333_3333;
    for (int t = 0; t < NT; t++) tgt_rdata[t] = trd[t];
    tgt_error = 4'b1000;
    drive(1'b1, 3'b000, T0, T0, T0, 4'b0000, 1'b0);

    //   rst dv      a0   a1   a2   thold    tdv      hold    err     gnt
    add(1, 3'b011, T0,  T0,  T0,  4'b0000, 4'b0000, 3'b011, 3'b000, 3'b000);
    add(0, 3'b111, T0,  T0,  T0,  4'b0000, 4'b0001, 3'b110, 3'b000, 3'b001);
    add(0, 3'b111, T0,  T0,  T0,  4'b0000, 4'b0001, 3'b101, 3'b000, 3'b010);
    add(0, 3'b111, T0,  T0,  T0,  4'b0000, 4'b0001, 3'b011, 3'b000, 3'b100);
    add(0, 3'b111, T0,  T0,  T0,  4'b0000, 4'b0001, 3'b110, 3'b000, 3'b001);
    add(0, 3'b111, T0,  T0,  T0,  4'b0000, 4'b0001, 3'b101, 3'b000, 3'b010);
    add(0, 3'b111, T0,  T0,  T0,  4'b0000, 4'b0001, 3'b011, 3'b000, 3'b100);
    add(0, 3'b010, T1,  T1,  T1,  4'b0010, 4'b0010, 3'b010, 3'b000, 3'b010);
    add(0, 3'b011, T1,  T1,  T1,  4'b0010, 4'b0010, 3'b011, 3'b000, 3'b010);
    add(0, 3'b011, T1,  T1,  T1,  4'b0010, 4'b0010, 3'b011, 3'b000, 3'b010);
    add(0, 3'b011, T1,  T1,  T1,  4'b0010, 4'b0010, 3'b011, 3'b000, 3'b010);
    add(0, 3'b011, T1,  T1,  T1,  4'b0000, 4'b0010, 3'b001, 3'b000, 3'b010);
    add(0, 3'b011, T1,  T1,  T1,  4'b0000, 4'b0010, 3'b010, 3'b000, 3'b001);
    add(0, 3'b011, T1,  T1,  T1,  4'b0000, 4'b0010, 3'b001, 3'b000, 3'b010);
    add(0, 3'b000, T0,  T0,  T0,  4'b0000, 4'b0000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b100, T0,  T0,  BAD, 4'b0000, 4'b0000, 3'b000, 3'b100, 3'b000);
    add(0, 3'b011, T0,  T2,  T0,  4'b0000, 4'b0101, 3'b000, 3'b000, 3'b011);
    add(0, 3'b100, T0,  T0,  T3,  4'b0000, 4'b1000, 3'b000, 3'b100, 3'b100);
    add(0, 3'b111, T1,  T2,  T3,  4'b0000, 4'b1110, 3'b000, 3'b100, 3'b111);
    add(0, 3'b010, T1,  T1,  T1,  4'b0010, 4'b0010, 3'b010, 3'b000, 3'b010);
    add(1, 3'b110, T1,  T1,  T1,  4'b0010, 4'b0000, 3'b110, 3'b000, 3'b000);
    add(0, 3'b110, T1,  T1,  T1,  4'b0000, 4'b0010, 3'b100, 3'b000, 3'b010);
    add(0, 3'b110, T1,  T1,  T1,  4'b0000, 4'b0010, 3'b010, 3'b000, 3'b100);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].r, vq[i].dv, vq[i].a0, vq[i].a1, vq[i].a2, vq[i].th, 1'b0);
      #2;
      chk($sformatf("v%0d tgt_req_dv", i), 128'(tgt_req_dv), 128'(vq[i].tdv));
      chk($sformatf("v%0d cli_req_hold", i), 128'(cli_req_hold), 128'(vq[i].hold));
      chk($sformatf("v%0d cli_error", i), 128'(cli_error), 128'(vq[i].err));
      for (int c = 0; c < NC; c++) begin
        exp_rd = vq[i].gnt[c] ? trd[tgt_of(av[c])] : 32'h0;
        chk($sformatf("v%0d cli_rdata[%0d]", i, c), 128'(cli_rdata[c]), 128'(exp_rd));
      end
      for (int t = 0; t < NT; t++) begin
        exp_d = '0;
        for (int c = 0; c < NC; c++)
          if (vq[i].gnt[c] && tgt_of(av[c]) == t) exp_d = cli_req_data[c];
        chk($sformatf("v%0d tgt_req_data[%0d]", i, t), 128'(tgt_req_data[t]), 128'(exp_d));
      end
    end

    // Client 2 on target 0: granted where permitted, decode error where masked off.
    @(negedge clk);
    drive(1'b0, 3'b100, T1, T1, T0, 4'b0000, 1'b0);
    #2;
    chk("perm tgt_req_dv", 128'(tgt_req_dv), 128'(4'b0001));
    chk("perm cli_error", 128'(cli_error), 128'(3'b000));
    chk("mask tgt_req_dv", 128'(b_tgt_req_dv), 128'(4'b0000));
    chk("mask cli_error", 128'(b_cli_error), 128'(3'b100));
    chk("mask cli_req_hold", 128'(b_cli_req_hold), 128'(3'b000));
    chk("mask cli_rdata[2]", 128'(b_cli_rdata[2]), 128'(0));

`ifdef SOC_IFC_ARB_COLL_CNT_EN
    chk("coll_cnt[0] after reset", 128'(coll_cnt[0]), 128'(0));
    chk("coll_cnt[1] after reset", 128'(coll_cnt[1]), 128'(2));
    @(negedge clk);
    drive(1'b0, 3'b011, T0, T0, T0, 4'b0000, 1'b0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("coll_cnt[0] saturate", 128'(coll_cnt[0]), 128'(16'hFFFF));
    drive(1'b0, 3'b011, T0, T0, T0, 4'b0000, 1'b1);
    @(negedge clk);
    chk("coll_cnt[0] clear prio", 128'(coll_cnt[0]), 128'(0));
    drive(1'b0, 3'b011, T0, T0, T0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("coll_cnt[0] restart", 128'(coll_cnt[0]), 128'(1));
`else
    chk("coll_cnt tied A", 128'(coll_cnt), 128'(0));
    chk("coll_cnt tied B", 128'(b_coll_cnt), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/soc_ifc_mc_arb.md
# soc_ifc_mc_arb

Parametrised multi-client, multi-target request arbiter for the SoC interface fabric. It sits between N requesting clients (uC, SoC AXI, DMA, debug) and M register/memory targets (mailbox, soc_ifc regs, SHA, DMA regs). Each target has its own round-robin arbiter with hold-based lock. Address decode and a static per-target client-permission mask select the target, and an optional per-target collision counter is available.

## Interface
Parameters:
- NUM_CLIENTS, 3, number of requesting clients (2..8)
- NUM_TGTS, 4, number of targets (1..8)
- TGT_START_ADDR, '0, packed NUM_TGTS×32 inclusive start address per target
- TGT_END_ADDR, '0, packed NUM_TGTS×32 inclusive end address per target; ranges must not overlap
- TGT_CLIENT_EN, '1, packed NUM_TGTS×NUM_CLIENTS mask; bit [t][c]=1 permits client c on target t

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- cli_req_dv  in  NUM_CLIENTS  per-client request valid
- cli_req_data  in  NUM_CLIENTS×soc_ifc_req_t  per-client request (addr, wdata, write, user)
- cli_req_hold  out  NUM_CLIENTS  per-client hold (stall)
- cli_rdata  out  NUM_CLIENTS×SOC_IFC_DATA_W  per-client read data
- cli_error  out  NUM_CLIENTS  per-client error
- tgt_req_dv  out  NUM_TGTS  per-target request valid
- tgt_req_data  out  NUM_TGTS×soc_ifc_req_t  granted client's request, zero if none
- tgt_req_hold  in  NUM_TGTS  target hold
- tgt_rdata  in  NUM_TGTS×SOC_IFC_DATA_W  target read data
- tgt_error  in  NUM_TGTS  target error
- coll_cnt  out  NUM_TGTS×16  per-target collision counts (see Configuration)
- coll_cnt_clr  in  1  clears all collision counters

## Operation
- Decode: client c hits target t when cli_req_dv[c], addr is in [TGT_START_ADDR[t]:TGT_END_ADDR[t]], and TGT_CLIENT_EN[t][c] is set. No hit means decode error.
- Decode error: cli_error[c]=1 and cli_req_hold[c]=0 in the same cycle. No target is driven.
- State per target: rr_ptr (clog2(NUM_CLIENTS) bits), lock_vld, lock_owner.
- Grant when lock_vld=1: only lock_owner may be granted.
- Grant when lock_vld=0: the first requesting client at or after rr_ptr, searched cyclically (rr_ptr, rr_ptr+1 … wrapping modulo NUM_CLIENTS), wins.
- Lock: granted & tgt_req_hold[t] sets lock_vld=1 and lock_owner=winner at the next edge. Granted & ~tgt_req_hold[t] clears lock_vld.
- If the lock owner drops dv while locked, lock_vld clears next cycle. This is a protocol violation, flagged by assertion.
- rr_ptr advances to winner+1 (mod NUM_CLIENTS) only when the transfer completes (granted & ~hold) and ≥2 clients hit the target in that cycle. An uncontended completion leaves rr_ptr unchanged.
- tgt_req_dv[t]=1 iff a grant exists. tgt_req_data[t] is the AND-OR mux of the winner's request.
- cli_req_hold[c]=1 if c hits t and (not granted, or tgt_req_hold[t]).
- cli_rdata[c]: tgt_rdata of the hit target when granted, else 0.
- cli_error[c]: tgt_error of the hit target when granted, or decode error.
- Simultaneous events: different targets are fully independent, so all clients may be granted in one cycle.

## Timing
- All client/target outputs are combinational from inputs plus state; there is zero added latency.
- A single-cycle transfer completes in the request cycle.
- Reset values (rst=1): rr_ptr=0, lock_vld=0, coll_cnt=0, tgt_req_dv=0, tgt_req_data=0, cli_error=0, cli_rdata=0, cli_req_hold=cli_req_dv.
- Reset mid-transfer: the lock is dropped. Arbitration restarts from client 0 on the first cycle after rst falls.
- A contended requester waits at most NUM_CLIENTS−1 completed transfers on that target.

## Configuration
- Macro SOC_IFC_ARB_COLL_CNT_EN.
- Defined: coll_cnt[t] increments by 1 on each completion with ≥2 hitting clients. It saturates at 16'hFFFF. coll_cnt_clr=1 zeroes it, and clear takes priority over increment.
- Undefined: no counter flops are instantiated. coll_cnt is tied to 0 and coll_cnt_clr is ignored.

## Test plan
- NUM_CLIENTS=3, clients 0/1/2 hit target 0 every cycle with hold=0 → grants go 0,1,2,0,1,2 on consecutive cycles.
- Client 1 granted on target 1 with hold=1 for 4 cycles while client 0 also requests → client 1 stays granted for all 4 cycles and cli_req_hold[0]=1 throughout. Client 0 is granted on the cycle after hold falls.
- Client 2 reads address outside all ranges → cli_error[2]=1, cli_req_hold[2]=0, all tgt_req_dv=0. The same applies when TGT_CLIENT_EN[0][2]=0 and client 2 hits target 0.
- Clients 0→target 0 and 1→target 2 in the same cycle → both granted. Their rdata 32'hA5A5_0000 and 32'h0000_5A5A are routed independently.
- Lock held by client 1, then rst pulsed for 1 cycle → lock_vld=0, tgt_req_dv=0 during reset. After reset with clients 1 and 2 requesting, client 1 is granted (rr_ptr=0).
- With SOC_IFC_ARB_COLL_CNT_EN: 70000 contended completions → coll_cnt[0]=16'hFFFF. Then coll_cnt_clr → 0. Without the macro → coll_cnt stays 0.
